// File: rtl/dm_reg_responder.sv
// Target-side responder: claims core data-memory requests inside the HOLLY
// register window and splits each 64-bit access into 32-bit register-bus beats.
module dm_reg_responder #(
  parameter logic [28:0] WIN_LO  = 29'h005F6800,
  parameter logic [28:0] WIN_HI  = 29'h005F9FFF,
  parameter int          TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] dm_req_addr,
  input  logic [63:0] dm_req_wdata,
  input  logic [7:0]  dm_req_wmask,
  input  logic        dm_req_wen,
  input  logic        dm_req_valid,
  output logic [63:0] dm_resp_rdata,
  output logic        dm_resp_valid,
  output logic        dm_resp_err,
  output logic [15:0] reg_addr,
  output logic [31:0] reg_wdata,
  output logic [3:0]  reg_be,
  output logic        reg_rd,
  output logic        reg_wr,
  input  logic [31:0] reg_rdata,
  input  logic        reg_ack
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BEAT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  logic [1:0]    state_q, state_d;
  logic [15:3]   addr_q, addr_d;
  logic [31:0]   wdata_hi_q, wdata_hi_d;
  logic [3:0]    be_hi_q, be_hi_d;
  logic          wen_q, wen_d;
  logic          hi_pending_q, hi_pending_d;
  logic          issue_q, issue_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   rword_q, rword_d;
  logic          err_q, err_d;
  logic [15:0]   reg_addr_q, reg_addr_d;
  logic [31:0]   reg_wdata_q, reg_wdata_d;
  logic [3:0]    reg_be_q, reg_be_d;

  logic in_win;
  logic claim;
  logic lo_any;
  logic hi_any;
  logic beat_done;
  logic unused_addr_hi;

  assign unused_addr_hi = ^dm_req_addr[31:29];

  assign in_win    = (dm_req_addr[28:0] >= WIN_LO) && (dm_req_addr[28:0] <= WIN_HI);
  assign claim     = (state_q == S_IDLE) && dm_req_valid && in_win;
  assign lo_any    = |dm_req_wmask[3:0];
  assign hi_any    = |dm_req_wmask[7:4];
  assign beat_done = reg_ack || (cnt_q == CW'(TIMEOUT - 1));

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    wdata_hi_d   = wdata_hi_q;
    be_hi_d      = be_hi_q;
    wen_d        = wen_q;
    hi_pending_d = hi_pending_q;
    issue_d      = 1'b0;
    cnt_d        = cnt_q;
    rword_d      = rword_q;
    err_d        = err_q;
    reg_addr_d   = reg_addr_q;
    reg_wdata_d  = reg_wdata_q;
    reg_be_d     = reg_be_q;

    case (state_q)
      S_IDLE: begin
        if (claim) begin
          addr_d       = dm_req_addr[15:3];
          wdata_hi_d   = dm_req_wdata[63:32];
          be_hi_d      = dm_req_wmask[7:4];
          wen_d        = dm_req_wen;
          err_d        = 1'b0;
          rword_d      = '0;
          cnt_d        = '0;
          hi_pending_d = 1'b0;
          if (!dm_req_wen) begin
            state_d    = S_BEAT;
            issue_d    = 1'b1;
            reg_addr_d = {dm_req_addr[15:2], 2'b00};
            reg_be_d   = 4'hF;
          end else if (lo_any) begin
            state_d      = S_BEAT;
            issue_d      = 1'b1;
            hi_pending_d = hi_any;
            reg_addr_d   = {dm_req_addr[15:3], 3'b000};
            reg_wdata_d  = dm_req_wdata[31:0];
            reg_be_d     = dm_req_wmask[3:0];
          end else if (hi_any) begin
            state_d     = S_BEAT;
            issue_d     = 1'b1;
            reg_addr_d  = {dm_req_addr[15:3], 3'b100};
            reg_wdata_d = dm_req_wdata[63:32];
            reg_be_d    = dm_req_wmask[7:4];
          end else begin
            state_d = S_RESP;
          end
        end
      end
      // A timed-out beat still completes; later beats of the same request run as usual.
      S_BEAT: begin
        cnt_d = cnt_q + CW'(1);
        if (beat_done) begin
          if (!reg_ack) begin
            err_d = 1'b1;
          end
          if (!wen_q) begin
            rword_d = reg_ack ? reg_rdata : 32'hFFFF_FFFF;
          end
          if (hi_pending_q) begin
            hi_pending_d = 1'b0;
            issue_d      = 1'b1;
            cnt_d        = '0;
            reg_addr_d   = {addr_q, 3'b100};
            reg_wdata_d  = wdata_hi_q;
            reg_be_d     = be_hi_q;
          end else begin
            state_d = S_RESP;
          end
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      wdata_hi_q   <= '0;
      be_hi_q      <= '0;
      wen_q        <= 1'b0;
      hi_pending_q <= 1'b0;
      issue_q      <= 1'b0;
      cnt_q        <= '0;
      rword_q      <= '0;
      err_q        <= 1'b0;
      reg_addr_q   <= '0;
      reg_wdata_q  <= '0;
      reg_be_q     <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      wdata_hi_q   <= wdata_hi_d;
      be_hi_q      <= be_hi_d;
      wen_q        <= wen_d;
      hi_pending_q <= hi_pending_d;
      issue_q      <= issue_d;
      cnt_q        <= cnt_d;
      rword_q      <= rword_d;
      err_q        <= err_d;
      reg_addr_q   <= reg_addr_d;
      reg_wdata_q  <= reg_wdata_d;
      reg_be_q     <= reg_be_d;
    end
  end

  assign reg_addr      = reg_addr_q;
  assign reg_wdata     = reg_wdata_q;
  assign reg_be        = reg_be_q;
  assign reg_rd        = (state_q == S_BEAT) && issue_q && !wen_q;
  assign reg_wr        = (state_q == S_BEAT) && issue_q && wen_q;
  assign dm_resp_valid = (state_q == S_RESP);
  assign dm_resp_err   = (state_q == S_RESP) && err_q;
  assign dm_resp_rdata = ((state_q == S_RESP) && !wen_q) ? {rword_q, rword_q} : 64'h0;

endmodule

// File: tb/tb_dm_reg_responder.sv
// Directed bench for dm_reg_responder: reads, split writes, window edges,
// timeout recovery and reset during a pending beat.
module tb_dm_reg_responder;

  logic        clk;
  logic        rst;
  logic [31:0] dm_req_addr;
  logic [63:0] dm_req_wdata;
  logic [7:0]  dm_req_wmask;
  logic        dm_req_wen;
  logic        dm_req_valid;
  logic [63:0] dm_resp_rdata;
  logic        dm_resp_valid;
  logic        dm_resp_err;
  logic [15:0] reg_addr;
  logic [31:0] reg_wdata;
  logic [3:0]  reg_be;
  logic        reg_rd;
  logic        reg_wr;
  logic [31:0] reg_rdata;
  logic        reg_ack;

  int nAsserts = 0;
  int nFails   = 0;

  dm_reg_responder dut (
    .clk          (clk),
    .rst          (rst),
    .dm_req_addr  (dm_req_addr),
    .dm_req_wdata (dm_req_wdata),
    .dm_req_wmask (dm_req_wmask),
    .dm_req_wen   (dm_req_wen),
    .dm_req_valid (dm_req_valid),
    .dm_resp_rdata(dm_resp_rdata),
    .dm_resp_valid(dm_resp_valid),
    .dm_resp_err  (dm_resp_err),
    .reg_addr     (reg_addr),
    .reg_wdata    (reg_wdata),
    .reg_be       (reg_be),
    .reg_rd       (reg_rd),
    .reg_wr       (reg_wr),
    .reg_rdata    (reg_rdata),
    .reg_ack      (reg_ack)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [63:0] wdata,
                               input logic [7:0] wmask, input logic wen, input logic valid);
    dm_req_addr  = addr;
    dm_req_wdata = wdata;
    dm_req_wmask = wmask;
    dm_req_wen   = wen;
    dm_req_valid = valid;
  endtask

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    nAsserts++;
    assert (observed === expected) else begin
      nFails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  initial begin
    int k;
    int hits;

    rst       = 1'b1;
    reg_ack   = 1'b0;
    reg_rdata = 32'h0;
    applyStimulus(32'h0, 64'h0, 8'h00, 1'b0, 1'b0);
    tick();
    tick();
    checkOutput("rst_resp_valid", {63'h0, dm_resp_valid}, 64'h0);
    checkOutput("rst_resp_rdata", dm_resp_rdata, 64'h0);
    checkOutput("rst_resp_err", {63'h0, dm_resp_err}, 64'h0);
    checkOutput("rst_strobes", {62'h0, reg_rd, reg_wr}, 64'h0);
    checkOutput("rst_reg_addr", {48'h0, reg_addr}, 64'h0);
    checkOutput("rst_reg_be", {60'h0, reg_be}, 64'h0);
    rst = 1'b0;
    tick();

    // Single-word read, ack in strobe cycle
    applyStimulus(32'h005F8004, 64'h0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("rd_strobe", {63'h0, reg_rd}, 64'h1);
    checkOutput("rd_addr", {48'h0, reg_addr}, 64'h8004);
    checkOutput("rd_be", {60'h0, reg_be}, 64'hF);
    checkOutput("rd_no_early_resp", {63'h0, dm_resp_valid}, 64'h0);
    reg_ack   = 1'b1;
    reg_rdata = 32'h12345678;
    tick();
    reg_ack = 1'b0;
    checkOutput("rd_resp_valid", {63'h0, dm_resp_valid}, 64'h1);
    checkOutput("rd_resp_rdata", dm_resp_rdata, 64'h12345678_12345678);
    checkOutput("rd_resp_err", {63'h0, dm_resp_err}, 64'h0);
    checkOutput("rd_strobe_once", {63'h0, reg_rd}, 64'h0);
    dm_req_valid = 1'b0;
    tick();
    checkOutput("rd_resp_pulse", {63'h0, dm_resp_valid}, 64'h0);
    checkOutput("rd_rdata_idle", dm_resp_rdata, 64'h0);

    // Full 64-bit write, ack two cycles late on each beat
    applyStimulus(32'h005F8010, 64'hAAAA5555_11112222, 8'hFF, 1'b1, 1'b1);
    tick();
    checkOutput("wr_lo_strobe", {63'h0, reg_wr}, 64'h1);
    checkOutput("wr_lo_addr", {48'h0, reg_addr}, 64'h8010);
    checkOutput("wr_lo_data", {32'h0, reg_wdata}, 64'h11112222);
    checkOutput("wr_lo_be", {60'h0, reg_be}, 64'hF);
    tick();
    checkOutput("wr_lo_strobe_once", {63'h0, reg_wr}, 64'h0);
    checkOutput("wr_lo_addr_held", {48'h0, reg_addr}, 64'h8010);
    tick();
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    checkOutput("wr_hi_strobe", {63'h0, reg_wr}, 64'h1);
    checkOutput("wr_hi_addr", {48'h0, reg_addr}, 64'h8014);
    checkOutput("wr_hi_data", {32'h0, reg_wdata}, 64'hAAAA5555);
    checkOutput("wr_mid_no_resp", {63'h0, dm_resp_valid}, 64'h0);
    tick();
    tick();
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    checkOutput("wr_resp_valid", {63'h0, dm_resp_valid}, 64'h1);
    checkOutput("wr_resp_rdata", dm_resp_rdata, 64'h0);
    checkOutput("wr_resp_err", {63'h0, dm_resp_err}, 64'h0);
    dm_req_valid = 1'b0;
    tick();
    checkOutput("wr_resp_once", {63'h0, dm_resp_valid}, 64'h0);

    // HI-only partial write
    applyStimulus(32'h005F8020, 64'h0000CAFE_DEADBEEF, 8'h30, 1'b1, 1'b1);
    tick();
    checkOutput("part_strobe", {63'h0, reg_wr}, 64'h1);
    checkOutput("part_addr", {48'h0, reg_addr}, 64'h8024);
    checkOutput("part_be", {60'h0, reg_be}, 64'h3);
    checkOutput("part_data", {32'h0, reg_wdata}, 64'h0000CAFE);
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    checkOutput("part_resp", {63'h0, dm_resp_valid}, 64'h1);
    dm_req_valid = 1'b0;
    tick();

    // Zero-mask write responds immediately without a strobe
    applyStimulus(32'h005F8030, 64'h1, 8'h00, 1'b1, 1'b1);
    tick();
    checkOutput("zero_resp", {63'h0, dm_resp_valid}, 64'h1);
    checkOutput("zero_no_strobe", {62'h0, reg_rd, reg_wr}, 64'h0);
    dm_req_valid = 1'b0;
    tick();

    // Just outside the window on both sides
    hits = 0;
    applyStimulus(32'h005F67FC, 64'h0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dm_resp_valid || reg_rd || reg_wr) hits++;
    end
    applyStimulus(32'h005FA000, 64'h0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (dm_resp_valid || reg_rd || reg_wr) hits++;
    end
    checkOutput("outside_window", 64'(hits), 64'h0);

    // Window edges are claimed
    applyStimulus(32'h005F6800, 64'h0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("win_lo_strobe", {63'h0, reg_rd}, 64'h1);
    checkOutput("win_lo_addr", {48'h0, reg_addr}, 64'h6800);
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    dm_req_valid = 1'b0;
    tick();
    applyStimulus(32'h005F9FFC, 64'h0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("win_hi_strobe", {63'h0, reg_rd}, 64'h1);
    checkOutput("win_hi_addr", {48'h0, reg_addr}, 64'h9FFC);
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    dm_req_valid = 1'b0;
    tick();

    // Read with no ack times out
    applyStimulus(32'h005F8008, 64'h0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("to_strobe", {63'h0, reg_rd}, 64'h1);
    k = 0;
    while (dm_resp_valid !== 1'b1 && k < 200) begin
      tick();
      k++;
    end
    checkOutput("to_latency", 64'(k), 64'd64);
    checkOutput("to_rdata", dm_resp_rdata, 64'hFFFFFFFF_FFFFFFFF);
    checkOutput("to_err", {63'h0, dm_resp_err}, 64'h1);
    dm_req_valid = 1'b0;
    tick();
    reg_ack = 1'b1;
    tick();
    tick();
    checkOutput("late_ack_ignored", {62'h0, dm_resp_valid, reg_rd}, 64'h0);
    reg_ack = 1'b0;
    tick();
    applyStimulus(32'h005F800C, 64'h0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("post_to_addr", {48'h0, reg_addr}, 64'h800C);
    reg_ack   = 1'b1;
    reg_rdata = 32'hCAFEF00D;
    tick();
    reg_ack = 1'b0;
    checkOutput("post_to_resp", {63'h0, dm_resp_valid}, 64'h1);
    checkOutput("post_to_rdata", dm_resp_rdata, 64'hCAFEF00D_CAFEF00D);
    checkOutput("post_to_err", {63'h0, dm_resp_err}, 64'h0);
    dm_req_valid = 1'b0;
    tick();

    // Reset while waiting on the HI beat
    applyStimulus(32'h005F8040, 64'h55667788_11223344, 8'hFF, 1'b1, 1'b1);
    tick();
    reg_ack = 1'b1;
    tick();
    reg_ack = 1'b0;
    checkOutput("rmw_hi_strobe", {63'h0, reg_wr}, 64'h1);
    checkOutput("rmw_hi_addr", {48'h0, reg_addr}, 64'h8044);
    tick();
    rst          = 1'b1;
    dm_req_valid = 1'b0;
    tick();
    rst = 1'b0;
    checkOutput("rmw_outputs_zero", {46'h0, reg_addr, dm_resp_valid, reg_wr}, 64'h0);
    checkOutput("rmw_wdata_zero", {32'h0, reg_wdata}, 64'h0);
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (dm_resp_valid || reg_wr || reg_rd) hits++;
    end
    checkOutput("rmw_no_resp", 64'(hits), 64'h0);
    applyStimulus(32'h005F8048, 64'h0, 8'h00, 1'b0, 1'b1);
    tick();
    checkOutput("rmw_read_strobe", {63'h0, reg_rd}, 64'h1);
    reg_ack   = 1'b1;
    reg_rdata = 32'h0BADF00D;
    tick();
    reg_ack = 1'b0;
    checkOutput("rmw_read_resp", {63'h0, dm_resp_valid}, 64'h1);
    checkOutput("rmw_read_rdata", dm_resp_rdata, 64'h0BADF00D_0BADF00D);
    dm_req_valid = 1'b0;
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", nAsserts, nFails);
    $finish;
  end

endmodule

// File: doc/dm_reg_responder.md
# dm_reg_responder

Target-side responder for the SH4 core data-memory request interface (`dm_req_*` / `dm_resp_*`). It claims requests whose address falls in a configurable HOLLY register window and converts each 64-bit request into one or two 32-bit strobed transfers on a simple register bus (ack-based, as used by the PVR/TA register files). It then returns a single `dm_resp_valid` pulse with the read data. It sits between the core and the HOLLY register blocks, in place of hard-wired read muxing.

## Interface
- `WIN_LO`, default 29'h005F6800: lowest claimed byte address, physical bits [28:0].
- `WIN_HI`, default 29'h005F9FFF: highest claimed byte address, inclusive.
- `TIMEOUT`, default 64: maximum wait in cycles for `reg_ack` per beat. Must be ≥ 2.
- `clk` in 1: single clock; all logic is posedge.
- `rst` in 1: synchronous, active-high reset.
- `dm_req_addr` in 32: byte address; only [28:0] is decoded.
- `dm_req_wdata` in 64: write data.
- `dm_req_wmask` in 8: byte enables; bit i covers wdata[8i+7:8i].
- `dm_req_wen` in 1: 1 = write, 0 = read.
- `dm_req_valid` in 1: request present.
- `dm_resp_rdata` out 64: read data, valid only while `dm_resp_valid` is high.
- `dm_resp_valid` out 1: one-cycle completion pulse.
- `dm_resp_err` out 1: qualifies `dm_resp_valid`; high if any beat timed out.
- `reg_addr` out 16: word-aligned byte address for the register bus (bits [1:0] are always 0).
- `reg_wdata` out 32: write data.
- `reg_be` out 4: byte enables.
- `reg_rd` out 1: one-cycle read strobe.
- `reg_wr` out 1: one-cycle write strobe.
- `reg_rdata` in 32: read data, sampled on `reg_ack`.
- `reg_ack` in 1: beat completion; may arrive in the strobe cycle or any later cycle.

## Operation
- **Claim:**
  - A request is claimed in IDLE when `dm_req_valid` is high and WIN_LO ≤ addr[28:0] ≤ WIN_HI.
  - Out-of-window requests are ignored entirely: no strobe and no response.
- **Capture:** on claim, addr, wdata, wmask and wen are registered. Inputs are don't-care after that until the response.
- **Reads:** exactly one beat at {addr[15:3], addr[2], 2'b00} with `reg_be`=4'hF. Response data is {rdata, rdata}, the word replicated into both halves.
- **Writes:**
  - LO beat at {addr[15:3],3'b000} with wdata[31:0] and be=wmask[3:0]. Issued only if wmask[3:0]≠0.
  - HI beat at {addr[15:3],3'b100} with wdata[63:32] and be=wmask[7:4]. Issued only if wmask[7:4]≠0.
  - LO is always issued before HI.
  - A write with wmask==0 issues no beat and responds directly.
  - Write responses return `dm_resp_rdata`=0.
- **States:**
  - IDLE → BEAT on claim with at least one beat; IDLE → RESP on claim with a zero-beat write.
  - BEAT issues the strobe, then waits for ack or timeout.
  - BEAT → BEAT when the HI beat is still pending after the LO beat; otherwise BEAT → RESP.
  - RESP pulses `dm_resp_valid`, then → IDLE.
- **Timeout:**
  - A per-beat counter is cleared at each strobe and counts waiting cycles.
  - If no ack by count TIMEOUT-1, the beat completes anyway: read word = 32'hFFFFFFFF and `dm_resp_err` is set for this response.
  - Remaining beats still run after a timeout.
- `reg_ack` outside BEAT-waiting, or a second ack after a beat has completed, is ignored.
- The core holds its request until `dm_resp_valid`. A request sampled in the cycle after RESP is treated as a new request.

## Timing
- **Reset values:** all outputs are 0; state = IDLE. The timeout counter and captured registers are cleared.
- **Reset mid-operation:** state returns to IDLE next cycle. No strobe and no response are produced for the aborted request.
- **Strobe rules:**
  - `reg_rd`/`reg_wr` are high for exactly one cycle per beat.
  - `reg_addr`/`reg_wdata`/`reg_be` are valid from the strobe cycle until ack, and are held stable.
- **Latency,** with the claim at cycle N:
  - Strobe at N+1.
  - With ack in the strobe cycle, `dm_resp_valid` at N+2 for a single beat and N+3 for two beats.
  - Each cycle of ack delay adds one cycle.
  - Zero-beat write: response at N+1.
- **Throughput:** at most one outstanding request. Back-to-back requests: next claim no earlier than the cycle after RESP.
- `dm_resp_err` and `dm_resp_rdata` are meaningful only in the RESP cycle; both are 0 otherwise.

## Test plan
- **Single-word read:** read addr 0x005F8004, ack in the strobe cycle with rdata 0x12345678 → `reg_rd` at N+1 with `reg_addr`=0x8004, `reg_be`=F; response at N+2 with rdata 0x12345678_12345678 and err=0.
- **Full 64-bit write:** write addr 0x005F8010, wmask 0xFF, wdata 0xAAAA5555_11112222, ack 2 cycles late on each beat → `reg_wr` at 0x8010 be=F with 0x11112222, then at 0x8014 with 0xAAAA5555; response exactly once, after the second ack.
- **Partial masks:** wmask 0x30 → only the HI beat, with be=4'b0011. wmask 0x00 → no strobe and response at N+1.
- **Window edges:** 0x005F67FC and 0x005FA000 → no strobe and no response for 20 cycles. 0x005F6800 and 0x005F9FFC → claimed.
- **Timeout:** TIMEOUT=64 and no ack on a read → response 64 cycles after the strobe with rdata 0xFFFFFFFF_FFFFFFFF and err=1. A late ack after that is ignored, and the next read completes normally with err=0.
- **Reset mid-wait:** assert `rst` during the HI-beat wait → all outputs 0 next cycle and no `dm_resp_valid`. A subsequent read completes normally.
